// File: rtl/debug_frame_capture_if.sv
// debug_frame_capture_if
//   Bundles the serial debug stream, the frame handshake and the status
//   outputs of debug_frame_capture. Clock and reset are not part of it.
//
//   master : the tag/host side (drives debug_in and frame_ack)
//   slave  : the capture block (drives frame data and status)
//
//   debug_in        serial bit from the tag's debug_out
//   frame_ack       consumer has taken frame_data
//   frame_data      captured snapshot, bit i = tag debug address i
//   frame_valid     frame_data holds an unconsumed frame
//   sync_locked     frame alignment is locked
//   sync_err_count  saturating count of marker mismatches while locked
//   overflow        sticky, a frame was dropped
//   frame_count     emitted-frame counter (zero unless DBG_FRAME_CNT_EN)
interface debug_frame_capture_if;
  logic        debug_in;
  logic        frame_ack;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        sync_locked;
  logic [3:0]  sync_err_count;
  logic        overflow;
  logic [7:0]  frame_count;

  modport master (
    output debug_in, frame_ack,
    input  frame_data, frame_valid, sync_locked, sync_err_count, overflow, frame_count
  );

  modport slave (
    input  debug_in, frame_ack,
    output frame_data, frame_valid, sync_locked, sync_err_count, overflow, frame_count
  );
endinterface

// File: rtl/debug_frame_capture.sv
// debug_frame_capture
//   Aligns to the tag's serial debug stream using the 4-bit marker carried
//   in addresses 12-15, rebuilds 16-bit status snapshots and offers them on
//   a valid/ack handshake. Reports lock, marker errors and dropped frames.
//
//   debug_clk  sample clock, shared with the tag's debug address counter
//   reset      asynchronous, active-high
//   dbg        debug_frame_capture_if.slave (stream, handshake, status)
//
//   Optional build macro DBG_FRAME_CNT_EN: when defined, dbg.frame_count is
//   an 8-bit wrapping count of accepted frames; otherwise it is tied to 0.
module debug_frame_capture #(
  parameter logic [3:0] SYNC_PATTERN   = 4'b1010,
  parameter int         LOSS_THRESHOLD = 2
) (
  input  logic                  debug_clk,
  input  logic                  reset,
  debug_frame_capture_if.slave  dbg
);

  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [1:0] LOSS_TH = LOSS_THRESHOLD[1:0];

  state_t      state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [3:0]  fill_q, fill_d;
  logic [1:0]  miss_q, miss_d;
  logic [15:0] frame_data_q, frame_data_d;
  logic        frame_valid_q, frame_valid_d;
  logic        sync_locked_q, sync_locked_d;
  logic [3:0]  err_q, err_d;
  logic        overflow_q, overflow_d;

  logic        match, boundary, hunt_ready, miss_limit, emit, accept;
  logic [1:0]  miss_inc;

  // Newest sample enters at the top, so after 16 samples address i is bit i.
  assign shreg_d    = {dbg.debug_in, shreg_q[15:1]};
  assign match      = (shreg_d[15:12] == SYNC_PATTERN);
  assign boundary   = (bitcnt_q == 4'd15) && (state_q != HUNT);
  // fill_q counts samples already taken in HUNT; the current one is the 16th.
  assign hunt_ready = (fill_q == 4'd15);
  assign miss_inc   = miss_q + 2'd1;
  assign miss_limit = (miss_inc >= LOSS_TH);

  // State register
  always_ff @(posedge debug_clk or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      shreg_q       <= '0;
      bitcnt_q      <= '0;
      fill_q        <= '0;
      miss_q        <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      sync_locked_q <= 1'b0;
      err_q         <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bitcnt_q      <= bitcnt_d;
      fill_q        <= fill_d;
      miss_q        <= miss_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      sync_locked_q <= sync_locked_d;
      err_q         <= err_d;
      overflow_q    <= overflow_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT: begin
        if (match && hunt_ready) state_d = VERIFY;
      end
      VERIFY: begin
        if (boundary) state_d = match ? LOCKED : HUNT;
      end
      LOCKED: begin
        if (boundary && !match && miss_limit) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  // Datapath and outputs
  always_comb begin
    // The sample after the HUNT match is address 0 of the next frame.
    bitcnt_d = bitcnt_q + 4'd1;
    if (state_q == HUNT && state_d == VERIFY) bitcnt_d = 4'd0;

    // Sample counting restarts on every HUNT entry.
    fill_d = 4'd0;
    if (state_q == HUNT && state_d == HUNT) fill_d = hunt_ready ? fill_q : fill_q + 4'd1;

    miss_d = (state_q == LOCKED) ? miss_q : 2'd0;
    err_d  = err_q;
    if (state_q == LOCKED && boundary) begin
      if (match || miss_limit) miss_d = 2'd0;
      else                     miss_d = miss_inc;
      if (!match && err_q != 4'hF) err_d = err_q + 4'd1;
    end

    emit   = boundary && match;
    accept = emit && (!frame_valid_q || dbg.frame_ack);

    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    overflow_d    = overflow_q;
    if (accept) begin
      frame_data_d  = shreg_d;
      frame_valid_d = 1'b1;
    end else if (emit) begin
      overflow_d = 1'b1;   // previous frame still pending: new one dropped
    end else if (dbg.frame_ack) begin
      frame_valid_d = 1'b0;
    end

    sync_locked_d = (state_d == LOCKED);
  end

  assign dbg.frame_data     = frame_data_q;
  assign dbg.frame_valid    = frame_valid_q;
  assign dbg.sync_locked    = sync_locked_q;
  assign dbg.sync_err_count = err_q;
  assign dbg.overflow       = overflow_q;

`ifdef DBG_FRAME_CNT_EN
  logic [7:0] frame_count_q, frame_count_d;

  always_comb frame_count_d = accept ? frame_count_q + 8'd1 : frame_count_q;

  always_ff @(posedge debug_clk or posedge reset) begin
    if (reset) frame_count_q <= '0;
    else       frame_count_q <= frame_count_d;
  end

  assign dbg.frame_count = frame_count_q;
`else
  assign dbg.frame_count = 8'h00;
`endif

endmodule

// File: tb/tb_debug_frame_capture.sv
// tb_debug_frame_capture
//   Drives serial frames into debug_frame_capture, records every frame the
//   DUT loads, and compares against frames queued when stimulus is sent.
module tb_debug_frame_capture;

  logic debug_clk = 1'b0;
  logic reset;

  debug_frame_capture_if dbg();

  debug_frame_capture dut (
    .debug_clk (debug_clk),
    .reset     (reset),
    .dbg       (dbg)
  );

  always #5 debug_clk = ~debug_clk;

`ifdef DBG_FRAME_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic        mon_prev_valid = 1'b0;

  // Records each frame load: valid newly high, or still high after an ack.
  initial forever begin
    @(posedge debug_clk);
    #1;
    if (dbg.frame_valid && (!mon_prev_valid || dbg.frame_ack)) obs_q.push_back(dbg.frame_data);
    mon_prev_valid = dbg.frame_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic clock_bit(input logic b);
    dbg.debug_in = b;
    @(negedge debug_clk);
  endtask

  task automatic send_frame(input logic [15:0] f);
    for (int i = 0; i < 16; i++) clock_bit(f[i]);
  endtask

  task automatic do_reset();
    @(negedge debug_clk);
    reset = 1'b1;
    dbg.debug_in = 1'b0;
    dbg.frame_ack = 1'b0;
    @(negedge debug_clk);
    @(negedge debug_clk);
    exp_q.delete();
    obs_q.delete();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge debug_clk);
    n_checks++; if (dbg.frame_data !== 16'h0) $display("FAIL reset_data: got %h expected %h", dbg.frame_data, 16'h0); else n_pass++;
    n_checks++; if (dbg.frame_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", dbg.frame_valid); else n_pass++;
    n_checks++; if (dbg.sync_locked !== 1'b0) $display("FAIL reset_locked: got %b expected 0", dbg.sync_locked); else n_pass++;
    n_checks++; if (dbg.sync_err_count !== 4'h0) $display("FAIL reset_err: got %h expected 0", dbg.sync_err_count); else n_pass++;
    n_checks++; if (dbg.overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", dbg.overflow); else n_pass++;
    n_checks++; if (dbg.frame_count !== 8'h00) $display("FAIL reset_count: got %h expected 00", dbg.frame_count); else n_pass++;
    $display("reset: outputs checked");
  endtask

  task automatic test_aligned();
    logic [15:0] o, e;
    do_reset();
    dbg.frame_ack = 1'b1;
    send_frame(16'hA0F3);
    n_checks++; if (dbg.frame_valid !== 1'b0) $display("FAIL aligned_no_early_emit: got %b expected 0", dbg.frame_valid); else n_pass++;
    n_checks++; if (dbg.sync_locked !== 1'b0) $display("FAIL aligned_not_locked_yet: got %b expected 0", dbg.sync_locked); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(16'hA0F3);
      send_frame(16'hA0F3);
      n_checks++; if (dbg.frame_valid !== 1'b1) $display("FAIL aligned_valid: got %b expected 1", dbg.frame_valid); else n_pass++;
      n_checks++; if (dbg.sync_locked !== 1'b1) $display("FAIL aligned_locked: got %b expected 1", dbg.sync_locked); else n_pass++;
    end
    n_checks++; if (dbg.sync_err_count !== 4'h0) $display("FAIL aligned_err: got %h expected 0", dbg.sync_err_count); else n_pass++;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL aligned_sb_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL aligned_sb_data: got %h expected %h", o, e); else begin n_pass++; $display("aligned: frame %h", o); end
    end
  endtask

  task automatic test_misaligned();
    logic [15:0] o, e;
    do_reset();
    dbg.frame_ack = 1'b1;
    for (int i = 0; i < 5; i++) clock_bit(1'b1);
    send_frame(16'hA5C0);
    n_checks++; if (obs_q.size() != 0) $display("FAIL misaligned_no_false_emit: got %0d expected 0", obs_q.size()); else n_pass++;
    n_checks++; if (dbg.sync_locked !== 1'b0) $display("FAIL misaligned_not_locked_yet: got %b expected 0", dbg.sync_locked); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(16'hA5C0);
      send_frame(16'hA5C0);
      n_checks++; if (dbg.sync_locked !== 1'b1) $display("FAIL misaligned_locked: got %b expected 1", dbg.sync_locked); else n_pass++;
      n_checks++; if (dbg.frame_data !== 16'hA5C0) $display("FAIL misaligned_data: got %h expected %h", dbg.frame_data, 16'hA5C0); else n_pass++;
    end
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL misaligned_sb_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL misaligned_sb_data: got %h expected %h", o, e); else begin n_pass++; $display("misaligned: frame %h", o); end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] o, e;
    logic [15:0] f;
    do_reset();
    dbg.frame_ack = 1'b1;
    send_frame(16'hA0F3);
    exp_q.push_back(16'hA0F3);
    send_frame(16'hA0F3);
    // keep ack high across the cycle that consumes the lock frame
    f = 16'hA001;
    exp_q.push_back(f);
    clock_bit(f[0]);
    dbg.frame_ack = 1'b0;
    for (int i = 1; i < 16; i++) clock_bit(f[i]);
    n_checks++; if (dbg.overflow !== 1'b0) $display("FAIL overflow_clear_first: got %b expected 0", dbg.overflow); else n_pass++;
    send_frame(16'hA002);
    n_checks++; if (dbg.overflow !== 1'b1) $display("FAIL overflow_set: got %b expected 1", dbg.overflow); else n_pass++;
    send_frame(16'hA003);
    n_checks++; if (dbg.frame_data !== 16'hA001) $display("FAIL overflow_data_held: got %h expected %h", dbg.frame_data, 16'hA001); else n_pass++;
    n_checks++; if (dbg.frame_valid !== 1'b1) $display("FAIL overflow_valid_held: got %b expected 1", dbg.frame_valid); else n_pass++;
    n_checks++; if (dbg.frame_count !== (CNT_EN ? 8'd2 : 8'd0)) $display("FAIL overflow_count: got %0d expected %0d", dbg.frame_count, (CNT_EN ? 8'd2 : 8'd0)); else n_pass++;
    dbg.frame_ack = 1'b1;
    clock_bit(1'b1);
    dbg.frame_ack = 1'b0;
    n_checks++; if (dbg.frame_valid !== 1'b0) $display("FAIL overflow_ack_clears: got %b expected 0", dbg.frame_valid); else n_pass++;
    n_checks++; if (dbg.overflow !== 1'b1) $display("FAIL overflow_sticky: got %b expected 1", dbg.overflow); else n_pass++;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL overflow_sb_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL overflow_sb_data: got %h expected %h", o, e); else begin n_pass++; $display("overflow: frame %h", o); end
    end
  endtask

  task automatic test_collision();
    logic [15:0] o, e;
    logic [15:0] f;
    do_reset();
    send_frame(16'hA0F3);
    exp_q.push_back(16'hA0F3);
    send_frame(16'hA0F3);
    f = 16'hA0F1;
    exp_q.push_back(f);
    for (int i = 0; i < 15; i++) clock_bit(f[i]);
    dbg.frame_ack = 1'b1;
    clock_bit(f[15]);
    dbg.frame_ack = 1'b0;
    n_checks++; if (dbg.frame_valid !== 1'b1) $display("FAIL collision_valid: got %b expected 1", dbg.frame_valid); else n_pass++;
    n_checks++; if (dbg.frame_data !== 16'hA0F1) $display("FAIL collision_data: got %h expected %h", dbg.frame_data, 16'hA0F1); else n_pass++;
    n_checks++; if (dbg.overflow !== 1'b0) $display("FAIL collision_overflow: got %b expected 0", dbg.overflow); else n_pass++;
    clock_bit(1'b0);
    n_checks++; if (dbg.frame_valid !== 1'b1) $display("FAIL collision_valid_hold: got %b expected 1", dbg.frame_valid); else n_pass++;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL collision_sb_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL collision_sb_data: got %h expected %h", o, e); else begin n_pass++; $display("collision: frame %h", o); end
    end
  endtask

  task automatic test_single_miss();
    logic [15:0] o, e;
    do_reset();
    dbg.frame_ack = 1'b1;
    send_frame(16'hA0F3);
    exp_q.push_back(16'hA0F3);
    send_frame(16'hA0F3);
    send_frame(16'hF000);
    n_checks++; if (dbg.sync_err_count !== 4'd1) $display("FAIL single_miss_err: got %0d expected 1", dbg.sync_err_count); else n_pass++;
    n_checks++; if (dbg.sync_locked !== 1'b1) $display("FAIL single_miss_locked: got %b expected 1", dbg.sync_locked); else n_pass++;
    n_checks++; if (dbg.frame_valid !== 1'b0) $display("FAIL single_miss_no_emit: got %b expected 0", dbg.frame_valid); else n_pass++;
    exp_q.push_back(16'hA0F3);
    send_frame(16'hA0F3);
    n_checks++; if (dbg.frame_valid !== 1'b1) $display("FAIL single_miss_resume: got %b expected 1", dbg.frame_valid); else n_pass++;
    n_checks++; if (dbg.sync_err_count !== 4'd1) $display("FAIL single_miss_err_hold: got %0d expected 1", dbg.sync_err_count); else n_pass++;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL single_miss_sb_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL single_miss_sb_data: got %h expected %h", o, e); else begin n_pass++; $display("single_miss: frame %h", o); end
    end
  endtask

  task automatic test_loss_of_sync();
    logic [15:0] o, e;
    do_reset();
    dbg.frame_ack = 1'b1;
    send_frame(16'hA0F3);
    exp_q.push_back(16'hA0F3);
    send_frame(16'hA0F3);
    send_frame(16'hF000);
    n_checks++; if (dbg.sync_locked !== 1'b1) $display("FAIL loss_first_miss_locked: got %b expected 1", dbg.sync_locked); else n_pass++;
    send_frame(16'hF000);
    n_checks++; if (dbg.sync_err_count !== 4'd2) $display("FAIL loss_err: got %0d expected 2", dbg.sync_err_count); else n_pass++;
    n_checks++; if (dbg.sync_locked !== 1'b0) $display("FAIL loss_unlocked: got %b expected 0", dbg.sync_locked); else n_pass++;
    send_frame(16'hA0F3);
    n_checks++; if (dbg.sync_locked !== 1'b0) $display("FAIL loss_verify_unlocked: got %b expected 0", dbg.sync_locked); else n_pass++;
    exp_q.push_back(16'hA0F3);
    send_frame(16'hA0F3);
    n_checks++; if (dbg.sync_locked !== 1'b1) $display("FAIL loss_relock: got %b expected 1", dbg.sync_locked); else n_pass++;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL loss_sb_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL loss_sb_data: got %h expected %h", o, e); else begin n_pass++; $display("loss: frame %h", o); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] o, e;
    logic [15:0] f;
    do_reset();
    send_frame(16'hA0F3);
    exp_q.push_back(16'hA0F3);
    send_frame(16'hA0F3);
    send_frame(16'hF000);
    send_frame(16'hA0F3);   // dropped: previous frame never acked
    n_checks++; if (dbg.sync_locked !== 1'b1) $display("FAIL midrst_pre_locked: got %b expected 1", dbg.sync_locked); else n_pass++;
    n_checks++; if (dbg.sync_err_count !== 4'd1) $display("FAIL midrst_pre_err: got %0d expected 1", dbg.sync_err_count); else n_pass++;
    n_checks++; if (dbg.overflow !== 1'b1) $display("FAIL midrst_pre_overflow: got %b expected 1", dbg.overflow); else n_pass++;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL midrst_sb_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL midrst_sb_data: got %h expected %h", o, e); else begin n_pass++; $display("midrst: frame %h", o); end
    end
    f = 16'hA0F3;
    for (int i = 0; i < 7; i++) clock_bit(f[i]);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (dbg.frame_data !== 16'h0) $display("FAIL midrst_data: got %h expected 0000", dbg.frame_data); else n_pass++;
    n_checks++; if (dbg.frame_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", dbg.frame_valid); else n_pass++;
    n_checks++; if (dbg.sync_locked !== 1'b0) $display("FAIL midrst_locked: got %b expected 0", dbg.sync_locked); else n_pass++;
    n_checks++; if (dbg.sync_err_count !== 4'h0) $display("FAIL midrst_err: got %h expected 0", dbg.sync_err_count); else n_pass++;
    n_checks++; if (dbg.overflow !== 1'b0) $display("FAIL midrst_overflow: got %b expected 0", dbg.overflow); else n_pass++;
    n_checks++; if (dbg.frame_count !== 8'h00) $display("FAIL midrst_count: got %h expected 00", dbg.frame_count); else n_pass++;
    @(negedge debug_clk);
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_frame_count();
    logic [15:0] o, e;
    int mism;
    do_reset();
    dbg.frame_ack = 1'b1;
    send_frame(16'hA0F3);
    exp_q.push_back(16'hA0F3);
    send_frame(16'hA0F3);
    n_checks++; if (dbg.frame_count !== (CNT_EN ? 8'd1 : 8'd0)) $display("FAIL count_first: got %0d expected %0d", dbg.frame_count, (CNT_EN ? 8'd1 : 8'd0)); else n_pass++;
    for (int k = 1; k < 260; k++) begin
      exp_q.push_back(16'hA0F3);
      send_frame(16'hA0F3);
    end
    n_checks++; if (dbg.frame_count !== (CNT_EN ? 8'd4 : 8'd0)) $display("FAIL count_wrap: got %0d expected %0d", dbg.frame_count, (CNT_EN ? 8'd4 : 8'd0)); else n_pass++;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL count_sb_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    mism = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin
        mism++;
        if (mism < 4) $display("count: frame %h vs %h differs", o, e);
      end
    end
    n_checks++; if (mism != 0) $display("FAIL count_sb_data: got %0d bad frames expected 0", mism); else begin n_pass++; $display("count: 260 frames compared"); end
  endtask

  initial begin
    reset = 1'b1;
    dbg.debug_in = 1'b0;
    dbg.frame_ack = 1'b0;
    test_reset();
    test_aligned();
    test_misaligned();
    test_overflow();
    test_collision();
    test_single_miss();
    test_loss_of_sync();
    test_reset_mid_frame();
    test_frame_count();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
